// File: rtl/mux_rr_sched.sv
// Round-robin scheduler for a registered 4:1 output mux: bounded bursts per owner,
// optional idle guard cycle between grants, and valid/source tags aligned to the mux output.
module mux_rr_sched #(
  parameter int BURST_MAX = 8,
  parameter int GUARD     = 1,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] mask,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       mux_en,
  output logic       out_vld,
  output logic [1:0] out_src,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GUARD} state_t;

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_vld_q;
  logic [1:0]       out_src_q;

  logic [3:0] elig;
  logic [2:0] pick_last, pick_own;

  // Returns {found, idx}; search starts at base+1 and wraps, so base itself is lowest priority.
  function automatic logic [2:0] rr_pick(input logic [3:0] e, input logic [1:0] base);
    logic [2:0] r;
    logic [1:0] idx;
    r = '0;
    for (int i = 4; i >= 1; i--) begin
      idx = base + 2'(i);
      if (e[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  assign elig      = req & ~mask;
  assign pick_last = rr_pick(elig, last_q);
  // On a burst exit the new last is the current owner, so rotate from sel_q directly.
  assign pick_own  = rr_pick(elig, sel_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      sel_q     <= '0;
      last_q    <= 2'd3;
      cnt_q     <= '0;
      out_vld_q <= 1'b0;
      out_src_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      out_vld_q <= mux_en;
      out_src_q <= sel_q;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_GUARD: begin
        gnt_d = '0;
        cnt_d = '0;
        if (pick_last[2]) begin
          state_d = S_BURST;
          gnt_d   = 4'b0001 << pick_last[1:0];
          sel_d   = pick_last[1:0];
          cnt_d   = CNT_W'(1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BURST: begin
        if (elig[sel_q] && (cnt_q < CNT_W'(BURST_MAX))) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          last_d = sel_q;
          gnt_d  = '0;
          cnt_d  = '0;
          if (GUARD != 0) begin
            state_d = S_GUARD;
          end else if (pick_own[2]) begin
            gnt_d = 4'b0001 << pick_own[1:0];
            sel_d = pick_own[1:0];
            cnt_d = CNT_W'(1);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // mux_en stays combinational so an owner's req drop suppresses data in the overrun cycle.
  always_comb begin
    mux_en = |(gnt_q & req);
    busy   = (state_q != S_IDLE);
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign out_vld = out_vld_q;
  assign out_src = out_src_q;

endmodule

// File: tb/tb_mux_rr_sched.sv
// Directed bench for mux_rr_sched: a GUARD=1 and a GUARD=0 instance share the same stimulus.
module tb_mux_rr_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, mask;

  logic [1:0] sel1, src1, sel0, src0;
  logic [3:0] gnt1, gnt0;
  logic       en1, vld1, busy1, en0, vld0, busy0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux_rr_sched #(.BURST_MAX(8), .GUARD(1), .CNT_W(8)) u_g1 (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .sel(sel1), .gnt(gnt1),
    .mux_en(en1), .out_vld(vld1), .out_src(src1), .busy(busy1));

  mux_rr_sched #(.BURST_MAX(8), .GUARD(0), .CNT_W(8)) u_g0 (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .sel(sel0), .gnt(gnt0),
    .mux_en(en0), .out_vld(vld0), .out_src(src0), .busy(busy0));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Lands 2 time units after a rising edge, well clear of it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int ow, ex;
    rst_n = 1'b0;
    req   = 4'hF;
    mask  = 4'h0;

    // 1: outputs stay clear while reset is held with requests pending
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t1 gnt1 k=%0d", k), 8'(gnt1), 8'h0);
      chk($sformatf("t1 gnt0 k=%0d", k), 8'(gnt0), 8'h0);
      chk($sformatf("t1 sel1 k=%0d", k), 8'(sel1), 8'h0);
      chk($sformatf("t1 vld1 k=%0d", k), 8'(vld1), 8'h0);
      chk($sformatf("t1 busy1 k=%0d", k), 8'(busy1), 8'h0);
    end
    req   = 4'h0;
    rst_n = 1'b1;
    tick();
    chk("t1 idle busy1", 8'(busy1), 8'h0);

    // 2: single requester 2; GUARD=1 gives 8 on / 1 off, GUARD=0 holds continuously
    req = 4'b0100;
    for (int k = 0; k < 30; k++) begin
      tick();
      chk($sformatf("t2 gnt1 k=%0d", k), 8'(gnt1), (k % 9 != 8) ? 8'h04 : 8'h00);
      chk($sformatf("t2 vld1 k=%0d", k), 8'(vld1), (k >= 1 && ((k - 1) % 9 != 8)) ? 8'h1 : 8'h0);
      chk($sformatf("t2 gnt0 k=%0d", k), 8'(gnt0), 8'h04);
      chk($sformatf("t2 sel1 k=%0d", k), 8'(sel1), 8'h2);
      if (k >= 1) chk($sformatf("t2 src1 k=%0d", k), 8'(src1), 8'h2);
    end
    req = 4'h0;
    tick();
    tick();
    chk("t2 end busy1", 8'(busy1), 8'h0);
    chk("t2 end busy0", 8'(busy0), 8'h0);
    chk("t2 end sel1 held", 8'(sel1), 8'h2);

    // 4: req[1] high for exactly three sampled edges from idle
    do_reset();
    req = 4'b0010;
    tick();
    chk("t4 k0 gnt1", 8'(gnt1), 8'h02);
    chk("t4 k0 en1", 8'(en1), 8'h1);
    chk("t4 k0 vld1", 8'(vld1), 8'h0);
    tick();
    chk("t4 k1 gnt1", 8'(gnt1), 8'h02);
    chk("t4 k1 vld1", 8'(vld1), 8'h1);
    tick();
    req = 4'b0000;
    #1;
    chk("t4 k2 gnt1 overrun", 8'(gnt1), 8'h02);
    chk("t4 k2 en1", 8'(en1), 8'h0);
    chk("t4 k2 vld1", 8'(vld1), 8'h1);
    tick();
    chk("t4 k3 gnt1", 8'(gnt1), 8'h00);
    chk("t4 k3 vld1", 8'(vld1), 8'h0);
    chk("t4 k3 busy1 guard", 8'(busy1), 8'h1);
    chk("t4 k3 busy0", 8'(busy0), 8'h0);
    tick();
    chk("t4 k4 busy1", 8'(busy1), 8'h0);
    chk("t4 k4 vld1", 8'(vld1), 8'h0);

    // 3: all requesting; rotation 0,1,2,3,0
    do_reset();
    req = 4'hF;
    for (int k = 0; k < 40; k++) begin
      tick();
      ow = (k / 8) % 4;
      chk($sformatf("t3 gnt0 k=%0d", k), 8'(gnt0), 8'(1 << ow));
      chk($sformatf("t3 sel0 k=%0d", k), 8'(sel0), 8'(ow));
      if (k >= 1) begin
        chk($sformatf("t3 vld0 k=%0d", k), 8'(vld0), 8'h1);
        chk($sformatf("t3 src0 k=%0d", k), 8'(src0), 8'(((k - 1) / 8) % 4));
      end
      ex = (k % 9 == 8) ? 0 : (1 << ((k / 9) % 4));
      chk($sformatf("t3 gnt1 k=%0d", k), 8'(gnt1), 8'(ex));
    end

    // 5: requester 0 masked; rotation 1,2,3,1
    do_reset();
    req  = 4'hF;
    mask = 4'b0001;
    for (int k = 0; k < 32; k++) begin
      tick();
      ow = 1 + (k / 8) % 3;
      chk($sformatf("t5 gnt0 k=%0d", k), 8'(gnt0), 8'(1 << ow));
    end
    mask = 4'h0;

    // 6: async reset in the 4th cycle of a burst on requester 3
    do_reset();
    req = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t6 gnt1 k=%0d", k), 8'(gnt1), 8'h08);
    end
    chk("t6 pre vld1", 8'(vld1), 8'h1);
    rst_n = 1'b0;
    #1;
    chk("t6 async gnt1", 8'(gnt1), 8'h0);
    chk("t6 async vld1", 8'(vld1), 8'h0);
    chk("t6 async sel1", 8'(sel1), 8'h0);
    chk("t6 async busy1", 8'(busy1), 8'h0);
    chk("t6 async en1", 8'(en1), 8'h0);
    req = 4'hF;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6 restart gnt1", 8'(gnt1), 8'h01);
    chk("t6 restart gnt0", 8'(gnt0), 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
